// File: rtl/stubs_by_layer.sv
// stubs_by_layer
// Per-layer stub buffer for one bunch crossing. Incoming stubs are written
// into a ping-pong register array (page chosen by the low bit of the BX
// counter), the stub count of the finished event is published on each new
// event strobe, and a reader fetches stored stubs by address with a
// two-cycle registered read. The start strobe is forwarded as done after
// TMUX cycles.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-low
//   en_proc    - reserved, ignored
//   start[1:0] - bit0 new-event strobe, bit1 pipelined reset
//   done[1:0]  - start delayed by TMUX cycles
//   data_in    - stub data, valid one cycle after enable
//   enable     - write request for the stub on data_in next cycle
//   number_out - stub count of the previous event (mod 64)
//   read_add   - read address, MSB = page, low bits = entry
//   data_out   - read data, two cycles after read_add
module stubs_by_layer #(
    parameter int MEM_SIZE   = 6,
    parameter int TMUX       = 6,
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_proc,
    input  logic [1:0]            start,
    output logic [1:0]            done,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  enable,
    output logic [5:0]            number_out,
    input  logic [MEM_SIZE:0]     read_add,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 2 ** (MEM_SIZE + 1);

    logic [2:0]            bx;
    logic                  bx_hold;     // write page, bx[0] one cycle late
    logic                  first_clk;
    logic [MEM_SIZE-1:0]   wr_add;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in_dly;
    logic                  enable_dly;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [1:0]            done_pipe [TMUX];

    logic unused_en_proc;
    assign unused_en_proc = en_proc;

    // Event control and write-address generation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bx          <= 3'b111;
            first_clk   <= 1'b0;
            wr_add      <= '1;
            wr_en       <= 1'b0;
            data_in_dly <= '0;
            enable_dly  <= 1'b0;
            number_out  <= '0;
        end else begin
            data_in_dly <= data_in;
            enable_dly  <= enable;

            // Pipelined reset wins over a coincident new-event strobe.
            if (start[1])
                bx <= 3'b111;
            else if (start[0])
                bx <= bx + 3'd1;
            first_clk <= start[0] & ~start[1];

            // Address sits at all ones between events so the first stub
            // lands at entry 0; the count is therefore last address + 1.
            if (first_clk) begin
                number_out <= 6'(wr_add + 1'b1);
                wr_add     <= '1;
                wr_en      <= 1'b0;
            end else if (enable_dly) begin
                wr_add <= wr_add + 1'b1;
                wr_en  <= 1'b1;
            end else begin
                wr_en  <= 1'b0;
            end
        end
    end

    // Plain pipeline register; settles to bx[0] within a cycle of reset.
    always_ff @(posedge clk) begin
        bx_hold <= bx[0];
    end

    // Register array: write port, registered read with output register.
    // Contents are intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{bx_hold, wr_add}] <= data_in_dly;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q    <= '0;
            data_out <= '0;
        end else begin
            mem_q    <= start[1] ? '0 : mem[read_add];
            data_out <= mem_q;
        end
    end

    // start -> done delay line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TMUX; i++)
                done_pipe[i] <= 2'b00;
        end else begin
            done_pipe[0] <= start;
            for (int i = 1; i < TMUX; i++)
                done_pipe[i] <= done_pipe[i-1];
        end
    end

    assign done = done_pipe[TMUX-1];

endmodule

// File: tb/tb_stubs_by_layer.sv
// Directed bench for stubs_by_layer: table of read-address / expected-stub
// records applied in a pipelined loop, plus hand-written sequences for
// reset, done delay, counting, overwrite, dropped writes and pipelined reset.
module tb_stubs_by_layer;

    localparam int MEM_SIZE = 6;
    localparam int TMUX     = 6;
    localparam int DW       = 36;

    logic          clk = 1'b0;
    logic          reset;
    logic          en_proc;
    logic [1:0]    start;
    logic [1:0]    done;
    logic [DW-1:0] data_in;
    logic          enable;
    logic [5:0]    number_out;
    logic [MEM_SIZE:0] read_add;
    logic [DW-1:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [MEM_SIZE:0] addr;
        logic [DW-1:0]     exp;
    } rd_vec_t;

    rd_vec_t rv [13];

    stubs_by_layer #(.MEM_SIZE(MEM_SIZE), .TMUX(TMUX), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .en_proc(en_proc), .start(start), .done(done),
        .data_in(data_in), .enable(enable), .number_out(number_out),
        .read_add(read_add), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // start[0] pulse; returns in the cycle where number_out is valid.
    task automatic start_pulse();
        start = 2'b01;
        step();
        start = 2'b00;
        step();
    endtask

    // Pipelined reads: address i driven in one cycle, data checked two
    // cycles later (one step after the next address is driven).
    task automatic run_reads(input int lo, input int hi);
        for (int i = lo; i <= hi + 1; i++) begin
            if (i <= hi) read_add = rv[i].addr;
            step();
            if (i > lo) check($sformatf("read[%0d] addr %0d", i - 1, rv[i-1].addr),
                              64'(data_out), 64'(rv[i-1].exp));
        end
    endtask

    initial begin
        rv[0]  = '{7'd0,  36'hA};
        rv[1]  = '{7'd1,  36'hB};
        rv[2]  = '{7'd2,  36'hC};
        rv[3]  = '{7'd64, 36'h1};
        rv[4]  = '{7'd0,  36'hA};
        rv[5]  = '{7'd0,  36'd164};
        rv[6]  = '{7'd1,  36'd101};
        rv[7]  = '{7'd63, 36'd163};
        rv[8]  = '{7'd64, 36'h1};
        rv[9]  = '{7'd64, 36'h55};
        rv[10] = '{7'd0,  36'd164};
        rv[11] = '{7'd1,  36'd101};
        rv[12] = '{7'd63, 36'd163};

        reset = 1'b0; en_proc = 1'b0; start = 2'b00; data_in = '0;
        enable = 1'b0; read_add = '0;

        // Reset state.
        step(); step();
        check("reset data_out", 64'(data_out), 64'd0);
        check("reset number_out", 64'(number_out), 64'd0);
        check("reset done", 64'(done), 64'd0);
        reset = 1'b1;
        step();
        check("no X on outputs", 64'({$isunknown(data_out), $isunknown(number_out), $isunknown(done)}), 64'd0);

        // Pipelined reset then new event; both delayed by TMUX.
        start = 2'b10; step();
        start = 2'b01; step();
        start = 2'b00;
        for (int i = 0; i < TMUX - 2; i++) step();
        check("done start[1]", 64'(done), 64'b10);
        step();
        check("done start[0]", 64'(done), 64'b01);
        step();
        check("done idle", 64'(done), 64'b00);
        check("number_out empty event", 64'(number_out), 64'd0);

        // Event on page 0: three stubs.
        enable = 1'b1;                step();
        enable = 1'b1; data_in = 'hA; step();
        enable = 1'b1; data_in = 'hB; step();
        enable = 1'b0; data_in = 'hC; step();
        data_in = '0; step(); step();
        run_reads(0, 2);

        // Next event on page 1: count of 3, one stub.
        start_pulse();
        check("number_out after 3", 64'(number_out), 64'd3);
        enable = 1'b1; step();
        enable = 1'b0; data_in = 'h1; step();
        data_in = '0; step(); step();
        run_reads(3, 4);

        // 65 stubs on page 0: last one overwrites entry 0.
        start_pulse();
        check("number_out after 1", 64'(number_out), 64'd1);
        for (int i = 0; i <= 65; i++) begin
            enable  = (i < 65);
            data_in = (i > 0) ? DW'(100 + i - 1) : '0;
            step();
        end
        enable = 1'b0; data_in = '0; step(); step();

        // New event with enable coincident with the first-clk cycle.
        start = 2'b01; enable = 1'b1; step();
        start = 2'b00; enable = 1'b0; data_in = 'h77; step();
        check("number_out after 65", 64'(number_out), 64'd1);
        data_in = '0; step(); step();
        run_reads(5, 8);
        start_pulse();
        check("number_out dropped write", 64'(number_out), 64'd0);

        // Pipelined reset: one zero read, bx back to 7 (page 1).
        read_add = 7'd64; step(); step();
        check("pre pipe-reset read", 64'(data_out), 64'h1);
        start = 2'b10; step();
        start = 2'b00; step();
        check("pipe-reset zero read", 64'(data_out), 64'd0);
        step();
        check("post pipe-reset read", 64'(data_out), 64'h1);
        enable = 1'b1; step();
        enable = 1'b0; data_in = 'h55; step();
        data_in = '0; step(); step();
        run_reads(9, 12);
        start_pulse();
        check("number_out after pipe reset", 64'(number_out), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stubs_by_layer.md
# stubs_by_layer

Per-layer stub buffer for the tracklet pipeline. Captures a stream of 36-bit stubs for one bunch-crossing (BX) event into a double-buffered (ping-pong) register-array memory, counts them, and exposes the stored stubs to a downstream reader by address. It also forwards the event `start` strobe as `done` after a fixed time-multiplex delay. The block is built from a `start`→`done` shift-register delay (pipe_delay function) and a dual-port register array with a registered read port (reg_array function).

## Interface
- `MEM_SIZE`, 6: address MSB index; memory depth 2^(MEM_SIZE+1), split into two pages of 2^MEM_SIZE.
- `TMUX`, 6: `start`→`done` delay in clock cycles (≥1).
- `DATA_WIDTH`, 36: stub width.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: one clock; reset is synchronous and active-low.
- `en_proc` in 1: reserved, ignored.
- `start` in 2: bit0 = new-event strobe; bit1 = pipelined reset.
- `done` out 2: `start` delayed by TMUX cycles.
- `data_in` in DATA_WIDTH: stub data, valid one cycle after `enable`.
- `enable` in 1: write request for the stub on `data_in` next cycle.
- `number_out` out 6: stub count of the previous event.
- `read_add` in MEM_SIZE+1: read address; MSB = page, low bits = entry.
- `data_out` out DATA_WIDTH: read data.

## Operation
- Reset (`reset`=0 at edge): bx counter=3'b111, first-clk flag=0, write address=all ones, write enable=0, delayed data/enable=0, `number_out`=0, `data_out`=0, memory output register=0, `done` pipeline=0. Memory contents not cleared.
- Pipelined reset (`start[1]`=1): bx counter←3'b111; memory output register←0; `start[0]` ignored that cycle. Other state unaffected.
- `start[0]`=1 (and `start[1]`=0): bx counter +1 (3-bit wrap); first-clk flag←1 next cycle, else ←0.
- Write page = bit0 of bx counter registered one cycle (bx_hold).
- Each cycle: data_in_dly←`data_in`, enable_dly←`enable`.
- First-clk cycle: `number_out`←(write address+1)[5:0]; write address←all ones; write enable←0 (any coincident enable_dly dropped).
- Otherwise: enable_dly=1 → write address +1, write enable←1; else write enable←0, address held.
- Memory write at edge with write enable=1: mem[{bx_hold[0], wr_add[MEM_SIZE-1:0]}]←data_in_dly. First stub of an event lands at entry 0; entries wrap modulo 2^MEM_SIZE within the page (overwrite).
- Read: mem output register←mem[`read_add`] every cycle; `data_out`←mem output register. Same-address read/write in one cycle returns old data.
- No writes in an event → `number_out`=0 at next start. Count >63 truncates mod 64.
- `done` = pure shift register of `start`, both bits, no other logic.

## Timing
- `enable` at cycle t, its stub on `data_in` at t+1; written at the edge ending t+2 (address/enable and data both registered).
- `start[0]` at t → bx counter updates at end of t; first-clk flag high during t+1; `number_out` valid from t+2; bx_hold (write page) toggles from t+2.
- Read latency 2: `read_add` at cycle t → `data_out` valid in cycle t+2. Fully pipelined, one read per cycle.
- `done[i]` in cycle t+TMUX equals `start[i]` in cycle t.
- Reset mid-event: write address returns to all ones; next write goes to entry 0 of page bx_hold[0] (page 1 after reset, as counter=7).

## Test plan
- Hold `reset`=0 two cycles → `data_out`=0, `number_out`=0, `done`=00; release; no X on outputs.
- `start`=10 one cycle, then `start`=01 one cycle at t → bx counter 0, `done`=10 then 01 exactly TMUX cycles later, page becomes 0 at t+2.
- After start, `enable`=1 for 3 cycles, `data_in`=0xA,0xB,0xC one cycle later → entries 0,1,2 of page 0; `read_add`=0,1,2 → `data_out`=0xA,0xB,0xC two cycles after each address.
- Next `start[0]` → `number_out`=3; write 0x1 → stored at page 1 entry 0 (`read_add`=64); page 0 still reads 0xA.
- Write 65 stubs in one event (MEM_SIZE=6) → stub 65 overwrites entry 0; next start gives `number_out`=1 (65 mod 64).
- `enable` asserted during first-clk cycle → that write dropped, `number_out` reflects prior event only; `start[1]` pulse → next `data_out` 0 for one read, bx counter back to 7.
